// File: rtl/mux4_arbiter_pkg.sv
// Shared types, sizes and the round-robin pick helper for the mux4 arbiter.
package mux4_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;
  localparam int CNT_W   = 4;

  // Arbiter FSM states: IDLE has no owner, OWN has exactly one granted requester.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_e;

  // Result of a round-robin scan: valid when any unmasked request was found.
  typedef struct packed {
    logic             valid;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // One-hot vector with bit idx set.
  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // First asserted, unmasked request scanning ptr, ptr+1, ... (mod NUM_REQ).
  // The scan runs from the farthest offset down so the nearest hit is written last.
  function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                    input logic [SEL_W-1:0]   ptr,
                                    input logic [NUM_REQ-1:0] mask);
    pick_t              p;
    logic [NUM_REQ-1:0] eff;
    logic [SEL_W-1:0]   idx;
    p   = '0;
    eff = req & ~mask;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ptr + SEL_W'(k);
      if (eff[idx]) begin
        p.valid = 1'b1;
        p.idx   = idx;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/mux4_arbiter_mux4.sv
// Plain combinational 4->1 single-bit multiplexer used for the arbiter output path.
module mux4
  import mux4_arb_pkg::*;
(
  input  logic             d0,
  input  logic             d1,
  input  logic             d2,
  input  logic             d3,
  input  logic [SEL_W-1:0] sel,
  output logic             z
);

  // Select one data bit; no storage on this path.
  always_comb begin
    z = d0;
    case (sel)
      2'd0:    z = d0;
      2'd1:    z = d1;
      2'd2:    z = d2;
      2'd3:    z = d3;
      default: z = d0;
    endcase
  end

endmodule

// File: rtl/mux4_arbiter.sv
// Round-robin arbiter for four single-bit requesters driving a shared mux4.
// Grants are registered and bounded to HOLD_MAX consecutive cycles (legal 1..15).
//
// Request/grant semantics: a requester holds req[i] high for as long as it wants
// the output; gnt[i] high in a cycle means it owns the mux that cycle. Dropping
// req[i] before an edge releases ownership at that edge with no extra cycle.
module mux4_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int HOLD_MAX = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] d,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic               z,
  output logic               busy,
  output logic [0:0]         dbg_state
);

  localparam logic [0:0]       ST_IDLE  = IDLE;
  localparam logic [0:0]       ST_OWN   = OWN;
  localparam logic [CNT_W-1:0] HOLD_CNT = CNT_W'(HOLD_MAX);

  logic [0:0]         state_q, state_n;
  logic [SEL_W-1:0]   ptr_q,   ptr_n;
  logic [CNT_W-1:0]   cnt_q,   cnt_n;
  logic [NUM_REQ-1:0] gnt_q,   gnt_n;
  logic [SEL_W-1:0]   sel_q,   sel_n;
  logic               busy_q,  busy_n;

  // Owner-side release terms; sel_q holds the current owner index while in OWN.
  logic               owner_req;
  logic               rel_hit;
  logic [SEL_W-1:0]   rel_ptr;
  logic [NUM_REQ-1:0] rel_mask;
  pick_t              pick_idle;
  pick_t              pick_rel;

  assign owner_req = req[sel_q];
  assign rel_hit   = !owner_req || (cnt_q == HOLD_CNT);
  assign rel_ptr   = sel_q + SEL_W'(1);
  // A dropped owner is excluded explicitly; an expired owner stays eligible so a
  // lone requester is simply re-granted.
  assign rel_mask  = owner_req ? {NUM_REQ{1'b0}} : onehot(sel_q);
  assign pick_idle = rr_pick(req, ptr_q, {NUM_REQ{1'b0}});
  assign pick_rel  = rr_pick(req, rel_ptr, rel_mask);

  // Next-state logic: arbitrate from IDLE, or hold/hand over from OWN.
  always_comb begin
    state_n = state_q;
    ptr_n   = ptr_q;
    cnt_n   = cnt_q;
    gnt_n   = gnt_q;
    sel_n   = sel_q;
    busy_n  = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_idle.valid) begin
          state_n = ST_OWN;
          gnt_n   = onehot(pick_idle.idx);
          sel_n   = pick_idle.idx;
          busy_n  = 1'b1;
          cnt_n   = CNT_W'(1);
        end else begin
          gnt_n  = '0;
          busy_n = 1'b0;
        end
      end
      ST_OWN: begin
        if (rel_hit) begin
          ptr_n = rel_ptr;
          if (pick_rel.valid) begin
            // Direct handover: no idle bubble between owners.
            gnt_n  = onehot(pick_rel.idx);
            sel_n  = pick_rel.idx;
            busy_n = 1'b1;
            cnt_n  = CNT_W'(1);
          end else begin
            // Nobody waiting: sel keeps pointing at the last owner.
            state_n = ST_IDLE;
            gnt_n   = '0;
            busy_n  = 1'b0;
          end
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
        gnt_n   = '0;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      ptr_q   <= ptr_n;
      cnt_q   <= cnt_n;
      gnt_q   <= gnt_n;
      sel_q   <= sel_n;
      busy_q  <= busy_n;
    end
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

  mux4 u_mux4 (
    .d0  (d[0]),
    .d1  (d[1]),
    .d2  (d[2]),
    .d3  (d[3]),
    .sel (sel_q),
    .z   (z)
  );

endmodule

// File: tb/tb_mux4_arbiter.sv
// Bench for mux4_arbiter: per-cycle scoreboard against a behavioural model plus
// directed checks for each scenario.
module tb_mux4_arbiter;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] d;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       z;
  logic       busy;
  logic [0:0] dbg_state;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];

  // Behavioural model state
  bit         m_own;
  logic [1:0] m_ptr;
  int         m_cnt;
  logic [3:0] m_gnt;
  logic [1:0] m_sel;
  logic       m_busy;

  mux4_arbiter #(.HOLD_MAX(HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .d         (d),
    .gnt       (gnt),
    .sel       (sel),
    .z         (z),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Advance the model by one rising edge with the given inputs.
  task automatic model_edge(input logic rst_v, input logic [3:0] r);
    int  o;
    int  w;
    bit  found;
    if (!rst_v) begin
      m_own = 0; m_ptr = 2'd0; m_cnt = 0; m_gnt = 4'b0; m_sel = 2'd0; m_busy = 1'b0;
    end else if (!m_own) begin
      found = 0; w = 0;
      for (int k = 0; k < 4; k++)
        if (!found && r[(m_ptr + k) % 4]) begin found = 1; w = (m_ptr + k) % 4; end
      if (found) begin
        m_own = 1; m_gnt = 4'b0001 << w; m_sel = 2'(w); m_busy = 1'b1; m_cnt = 1;
      end
    end else begin
      o = int'(m_sel);
      if (!r[o] || m_cnt == HOLD) begin
        m_ptr = 2'((o + 1) % 4);
        found = 0; w = 0;
        for (int k = 0; k < 4; k++)
          if (!found && r[(m_ptr + k) % 4]) begin found = 1; w = (m_ptr + k) % 4; end
        if (found) begin
          m_gnt = 4'b0001 << w; m_sel = 2'(w); m_busy = 1'b1; m_cnt = 1;
        end else begin
          m_own = 0; m_gnt = 4'b0; m_busy = 1'b0;
        end
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
  endtask

  // Driver: apply inputs, push the expected post-edge outputs, step one edge.
  task automatic drive(input logic rst_v, input logic [3:0] r, input logic [3:0] dv);
    rst_n = rst_v;
    req   = r;
    d     = dv;
    model_edge(rst_v, r);
    exp_q.push_back({m_gnt, m_sel, m_busy, dv[m_sel]});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] e;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 4'b1111, 4'b0001);
      e = exp_q.pop_front();
      checks++;
      if ({gnt, sel, busy, z} !== e) begin
        errors++;
        $display("FAIL reset_sb: got gnt/sel/busy/z=%b want %b", {gnt, sel, busy, z}, e);
      end
    end
    checks++;
    if ({gnt, sel, busy, z} !== 8'b0000_00_0_1) begin
      errors++;
      $display("FAIL reset_values: got gnt=%b sel=%0d busy=%b z=%b want 0000/0/0/1", gnt, sel, busy, z);
    end
  endtask

  task automatic test_single();
    logic [7:0] e;
    drive(1'b1, 4'b0100, 4'b0100);
    e = exp_q.pop_front();
    checks++;
    if ({gnt, sel, busy, z} !== e) begin
      errors++;
      $display("FAIL single_sb: got %b want %b", {gnt, sel, busy, z}, e);
    end
    checks++;
    if (gnt !== 4'b0100 || sel !== 2'd2 || z !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_grant: got gnt=%b sel=%0d z=%b busy=%b want 0100/2/1/1", gnt, sel, z, busy);
    end
    // z is combinational through the mux: must follow d within the cycle
    d = 4'b1011;
    #1;
    checks++;
    if (z !== 1'b0) begin
      errors++;
      $display("FAIL z_follows_d: got z=%b want 0", z);
    end
    drive(1'b1, 4'b0000, 4'b0100);
    e = exp_q.pop_front();
    checks++;
    if ({gnt, sel, busy, z} !== e) begin
      errors++;
      $display("FAIL single_drop_sb: got %b want %b", {gnt, sel, busy, z}, e);
    end
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || sel !== 2'd2) begin
      errors++;
      $display("FAIL single_release: got gnt=%b busy=%b sel=%0d want 0000/0/2", gnt, busy, sel);
    end
  endtask

  task automatic test_contention();
    logic [7:0] e;
    logic [3:0] want;
    drive(1'b0, 4'b0000, 4'b0000);
    void'(exp_q.pop_front());
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 4'b1111, 4'($urandom_range(0, 15)));
      e = exp_q.pop_front();
      want = 4'b0001 << ((i / 4) % 4);
      checks++;
      if ({gnt, sel, busy, z} !== e || gnt !== want) begin
        errors++;
        $display("FAIL contention_c%0d: got gnt=%b full=%b want gnt=%b full=%b", i, gnt, {gnt, sel, busy, z}, want, e);
      end
    end
  endtask

  task automatic test_lone();
    logic [7:0] e;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 4'b0010, 4'($urandom_range(0, 15)));
      e = exp_q.pop_front();
      checks++;
      if ({gnt, sel, busy, z} !== e || gnt !== 4'b0010 || busy !== 1'b1) begin
        errors++;
        $display("FAIL lone_c%0d: got gnt=%b busy=%b full=%b want 0010/1 full=%b", i, gnt, busy, {gnt, sel, busy, z}, e);
      end
    end
  endtask

  task automatic test_early_release();
    logic [7:0] e;
    logic [3:0] req_seq [6];
    logic [3:0] gnt_want[6];
    req_seq  = '{4'b0000, 4'b0100, 4'b1101, 4'b1001, 4'b1001, 4'b0001};
    gnt_want = '{4'b0000, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001};
    for (int i = 0; i < 6; i++) begin
      drive(i != 0, req_seq[i], 4'($urandom_range(0, 15)));
      e = exp_q.pop_front();
      checks++;
      if ({gnt, sel, busy, z} !== e || gnt !== gnt_want[i]) begin
        errors++;
        $display("FAIL early_release_s%0d: got gnt=%b full=%b want gnt=%b full=%b", i, gnt, {gnt, sel, busy, z}, gnt_want[i], e);
      end
    end
  endtask

  task automatic test_reset_mid_grant();
    logic [7:0] e;
    logic       rst_seq [6];
    logic [3:0] req_seq [6];
    logic [3:0] gnt_want[6];
    // Owner 1 hands to owner 2 so the pointer is non-zero before reset hits.
    rst_seq  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    req_seq  = '{4'b0000, 4'b0110, 4'b0100, 4'b0100, 4'b1010, 4'b1010};
    gnt_want = '{4'b0000, 4'b0010, 4'b0100, 4'b0000, 4'b0000, 4'b0010};
    for (int i = 0; i < 6; i++) begin
      drive(rst_seq[i], req_seq[i], 4'($urandom_range(0, 15)));
      e = exp_q.pop_front();
      checks++;
      if ({gnt, sel, busy, z} !== e || gnt !== gnt_want[i]) begin
        errors++;
        $display("FAIL reset_mid_s%0d: got gnt=%b full=%b want gnt=%b full=%b", i, gnt, {gnt, sel, busy, z}, gnt_want[i], e);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] e;
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 39) != 0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      e = exp_q.pop_front();
      checks++;
      if ({gnt, sel, busy, z} !== e) begin
        errors++;
        $display("FAIL random_c%0d: got gnt/sel/busy/z=%b want %b", i, {gnt, sel, busy, z}, e);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0;
    d     = 4'b0;
    test_reset();
    test_single();
    test_contention();
    test_lone();
    test_early_release();
    test_reset_mid_grant();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
